sdrd_byte_assembler: RTL

- Sits directly downstream of the serial-read sequencer PAL, which drives SDRD during qualified reads of the 0x1000–0x1FFF window.
- Samples one SDRD bit per qualified bus read and shifts it into a byte.
- Presents each completed byte on a valid/ready interface to the host-side register file.
- Detects framing aborts, inter-bit timeouts and overruns.

---
 rtl/sdrd_pkg.sv | 25 ++
 rtl/sdrd_hold_reg.sv | 52 +++++
 rtl/sdrd_byte_assembler.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/sdrd_pkg.sv
// Shared definitions for the SDRD serial-read byte assembler: FSM states,
// read-window decode constants and the qualified-strobe decode.
package sdrd_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } sdrd_state_t;

    // 0x1000-0x1FFF window: BA13 low, BA12 high
    localparam logic WIN_BA13 = 1'b0;
    localparam logic WIN_BA12 = 1'b1;

    // Must stay identical to the sequencer PAL's enable term
    function automatic logic sdrd_qual(
        input logic bus_strobe,
        input logic sser,
        input logic ba13,
        input logic ba12,
        input logic br_w
    );
        return bus_strobe & ~sser & (ba13 == WIN_BA13) & (ba12 == WIN_BA12) & br_w;
    endfunction

endpackage

// File: rtl/sdrd_hold_reg.sv
// Valid/ready holding register for assembled words, with sticky overrun
// when a word completes while the previous one is still unconsumed.
module sdrd_hold_reg #(
    parameter int BITS = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [BITS-1:0] word,
    input  logic            byte_ready,
    input  logic            clr_err,
    output logic [BITS-1:0] byte_data,
    output logic            byte_valid,
    output logic            overrun
);

    logic [BITS-1:0] data_reg;
    logic            valid_reg;
    logic            overrun_reg;
    logic            blocked;

    // A full register that is not being drained this edge drops the new word
    assign blocked = load & valid_reg & ~byte_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_reg    <= '0;
            valid_reg   <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            if (load) begin
                if (!blocked) begin
                    data_reg  <= word;
                    valid_reg <= 1'b1;
                end
            end else if (valid_reg && byte_ready) begin
                valid_reg <= 1'b0;
            end

            if (blocked) begin
                overrun_reg <= 1'b1;
            end else if (clr_err) begin
                overrun_reg <= 1'b0;
            end
        end
    end

    assign byte_data  = data_reg;
    assign byte_valid = valid_reg;
    assign overrun    = overrun_reg;

endmodule

// File: rtl/sdrd_byte_assembler.sv
// Collects one SDRD bit per qualified bus read into a BITS-wide word and hands
// completed words to the holding register; aborts on undriven SDRD or timeout.
module sdrd_byte_assembler
    import sdrd_pkg::*;
#(
    parameter int BITS      = 8,
    parameter bit LSB_FIRST = 1'b1,
    parameter int TIMEOUT   = 255
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       bus_strobe,
    input  logic                       sser,
    input  logic                       ba13,
    input  logic                       ba12,
    input  logic                       br_w,
    input  logic                       sdrd_in,
    input  logic                       sdrd_oe,
    output logic [BITS-1:0]            byte_data,
    output logic                       byte_valid,
    input  logic                       byte_ready,
    output logic [$clog2(BITS+1)-1:0]  bit_count,
    output logic                       busy,
    output logic                       overrun,
    output logic                       frame_err,
    input  logic                       clr_err
);

    localparam int CW = $clog2(BITS + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    sdrd_state_t     state_reg, state_next;
    logic [BITS-1:0] shift_reg, shift_next, shift_in;
    logic [CW-1:0]   count_reg, count_next;
    logic [TW-1:0]   tmo_reg, tmo_next, tmo_inc;
    logic            frame_err_reg;
    logic            qual, abort, complete;

    assign qual = sdrd_qual(bus_strobe, sser, ba13, ba12, br_w);

    // shift_in is the shift register with sdrd_in already shifted in
    genvar gi;
    for (gi = 0; gi < BITS; gi++) begin : g_shift
        if (LSB_FIRST) begin : g_lsb
            if (gi == BITS - 1) begin : g_entry
                assign shift_in[gi] = sdrd_in;
            end else begin : g_move
                assign shift_in[gi] = shift_reg[gi+1];
            end
        end else begin : g_msb
            if (gi == 0) begin : g_entry
                assign shift_in[gi] = sdrd_in;
            end else begin : g_move
                assign shift_in[gi] = shift_reg[gi-1];
            end
        end
    end

    assign tmo_inc = (tmo_reg == TW'(TIMEOUT)) ? tmo_reg : tmo_reg + TW'(1);

    always_comb begin
        state_next = state_reg;
        shift_next = shift_reg;
        count_next = count_reg;
        tmo_next   = tmo_reg;
        abort      = 1'b0;
        complete   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (qual && sdrd_oe) begin
                    shift_next = shift_in;
                    count_next = CW'(1);
                    tmo_next   = '0;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (qual) begin
                    if (sdrd_oe) begin
                        shift_next = shift_in;
                        tmo_next   = '0;
                        if (count_reg == CW'(BITS - 1)) begin
                            complete   = 1'b1;
                            shift_next = '0;
                            count_next = '0;
                            state_next = IDLE;
                        end else begin
                            count_next = count_reg + CW'(1);
                        end
                    end else begin
                        abort = 1'b1;
                    end
                end else if (tmo_inc == TW'(TIMEOUT)) begin
                    abort = 1'b1;
                end else begin
                    tmo_next = tmo_inc;
                end
            end
            default: state_next = IDLE;
        endcase

        if (abort) begin
            shift_next = '0;
            count_next = '0;
            tmo_next   = '0;
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            shift_reg     <= '0;
            count_reg     <= '0;
            tmo_reg       <= '0;
            frame_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            shift_reg     <= shift_next;
            count_reg     <= count_next;
            tmo_reg       <= tmo_next;
            frame_err_reg <= abort;
        end
    end

    sdrd_hold_reg #(
        .BITS(BITS)
    ) u_hold (
        .clk       (clk),
        .rst       (rst),
        .load      (complete),
        .word      (shift_in),
        .byte_ready(byte_ready),
        .clr_err   (clr_err),
        .byte_data (byte_data),
        .byte_valid(byte_valid),
        .overrun   (overrun)
    );

    assign bit_count = count_reg;
    assign busy      = (state_reg == SHIFT);
    assign frame_err = frame_err_reg;

endmodule
